seq_divider: RTL and testbench

- Unsigned restoring divider, one quotient bit per clock.
- Computes each trial subtraction with the team's ripple-carry add/subtract datapath: adder carry_in=1 inverts b and adds 1, so carry_out=1 means no borrow.
- Sits directly around that adder: registers the operands, sequences the iterations, and consumes the adder's sum and carry-out.
- Used wherever an integer quotient/remainder is needed and area matters more than latency.

---
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
// Trial subtractions run through an explicit ripple-carry add/subtract chain (carry_in=1, carry_out=1 means no borrow).
module seq_divider #(
    parameter int bit_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [bit_width-1:0] dividend,
    input  logic [bit_width-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [bit_width-1:0] quotient,
    output logic [bit_width-1:0] remainder,
    output logic                 div_by_zero
);
    localparam int CW = $clog2(bit_width);
    localparam logic [CW-1:0] LAST_ITER = CW'(bit_width - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg;
    logic [bit_width:0]   r_reg;
    logic [bit_width-1:0] q_reg;
    logic [bit_width-1:0] divisor_reg;
    logic [CW-1:0]        count_reg;

    logic [bit_width:0]   add_a;
    logic [bit_width:0]   add_b;
    logic [bit_width:0]   add_sum;
    logic [bit_width+1:0] carry;
    logic                 carry_out;
    logic [bit_width:0]   r_next;
    logic [bit_width-1:0] q_next;
    logic                 unused_r_msb;

    // The top bit of R is always 0 between iterations because R < divisor.
    assign unused_r_msb = r_reg[bit_width];

    assign add_a    = {r_reg[bit_width-1:0], q_reg[bit_width-1]};
    assign add_b    = {1'b0, divisor_reg};
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi <= bit_width; gi++) begin : g_ripple
            logic b_inv;
            assign b_inv         = ~add_b[gi];
            assign add_sum[gi]   = add_a[gi] ^ b_inv ^ carry[gi];
            assign carry[gi + 1] = (add_a[gi] & b_inv) | (carry[gi] & (add_a[gi] ^ b_inv));
        end
    endgenerate

    assign carry_out = carry[bit_width+1];
    assign r_next    = carry_out ? add_sum : add_a;
    assign q_next    = {q_reg[bit_width-2:0], carry_out};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            r_reg       <= '0;
            q_reg       <= '0;
            divisor_reg <= '0;
            count_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        divisor_reg <= divisor;
                        q_reg       <= dividend;
                        r_reg       <= '0;
                        count_reg   <= '0;
                        div_by_zero <= 1'b0;
                        done        <= 1'b0;
                        if (divisor == '0) begin
                            // No iterations needed: results are known on the accept edge.
                            state_reg   <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    r_reg     <= r_next;
                    q_reg     <= q_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_ITER) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[bit_width-1:0];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus tasks push expected results, a monitor pops them on each done pulse.
module tb_seq_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic [W-1:0] a;
        logic [W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    seq_divider #(.bit_width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every done pulse consumes one expected entry.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got q=%h r=%h dbz=%b, required no done", quotient, remainder, div_by_zero);
            end else begin
                e = exp_q.pop_front();
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                    n_err++;
                    $display("FAIL result %0d/%0d: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                             e.a, e.d, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
                end else begin
                    $display("div %0d/%0d -> q=%0d r=%0d dbz=%b", e.a, e.d, quotient, remainder, div_by_zero);
                end
                if (e.d != 0) begin
                    n_vec++;
                    if (longint'(quotient) * longint'(e.d) + longint'(remainder) != longint'(e.a) || remainder >= e.d) begin
                        n_err++;
                        $display("FAIL invariant %0d/%0d: got q=%0d r=%0d, required q*d+r==a and r<d", e.a, e.d, quotient, remainder);
                    end
                end
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        if (d == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / d; e.r = a % d; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drive one start pulse, then count cycles until done (bounded).
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] d, output int lat, output int busy_cnt);
        @(negedge clk);
        dividend = a; divisor = d; start = 1'b1;
        exp_q.push_back(model(a, d));
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_err++;
            $display("FAIL reset: got busy=%b done=%b q=%h r=%h dbz=%b, required all 0", busy, done, quotient, remainder, div_by_zero);
        end else $display("reset: outputs all zero");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_div(16'd100, 16'd7, lat, bc);
        n_vec++;
        if (lat != 17 || bc != 16) begin
            n_err++;
            $display("FAIL basic_latency: got done cycle %0d busy cycles %0d, required 17 and 16", lat, bc);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || quotient !== 16'd14 || remainder !== 16'd2) begin
            n_err++;
            $display("FAIL done_pulse_hold: got done=%b q=%0d r=%0d, required done=0 q=14 r=2", done, quotient, remainder);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] ta [4] = '{16'hFFFF, 16'hFFFF, 16'd5, 16'd0};
        logic [W-1:0] td [4] = '{16'd1, 16'hFFFF, 16'd9, 16'd3};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], td[i], lat, bc);
            n_vec++;
            if (lat != 17) begin
                n_err++;
                $display("FAIL extreme_latency %0d: got %0d, required 17", i, lat);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_div(16'h1234, 16'd0, lat, bc);
        n_vec++;
        if (lat != 1 || bc != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL div_zero_timing: got done cycle %0d busy cycles %0d, required 1 and 0", lat, bc);
        end
    endtask

    task automatic test_start_while_busy();
        int k;
        @(negedge clk);
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        exp_q.push_back(model(16'd100, 16'd7));
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            if (k == 5) begin dividend = 16'd50; divisor = 16'd5; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_vec++;
        if (k != 17) begin
            n_err++;
            $display("FAIL busy_ignore_latency: got done cycle %0d, required 17", k);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b done=%b q=%h r=%h dbz=%b, required all 0", busy, done, quotient, remainder, div_by_zero);
        end else $display("mid-run reset: outputs all zero");
        run_div(16'd1000, 16'd3, lat, bc);
        n_vec++;
        if (lat != 17) begin
            n_err++;
            $display("FAIL post_reset_latency: got %0d, required 17", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [4] = '{16'd999, 16'd65000, 16'd12345, 16'd7};
        logic [W-1:0] td [4] = '{16'd10, 16'd255, 16'd1, 16'd8};
        int k;
        @(negedge clk);
        dividend = ta[0]; divisor = td[0]; start = 1'b1;
        exp_q.push_back(model(ta[0], td[0]));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            k = 1;
            while (done !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            n_vec++;
            if (k != 17) begin
                n_err++;
                $display("FAIL back_to_back_spacing %0d: got %0d, required 17", i, k);
            end
            if (i < 4) begin
                dividend = ta[i]; divisor = td[i];
                exp_q.push_back(model(ta[i], td[i]));
            end else start = 1'b0;
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [W-1:0] a, d;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            d = (i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom_range(1, 65535));
            run_div(a, d, lat, bc);
            if (lat != 17) begin
                n_vec++;
                n_err++;
                $display("FAIL random_latency %0d/%0d: got %0d, required 17", a, d, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
